// File: rtl/i2c_slave_regs.sv
`timescale 1ns/1ps
// I2C target with one 7-bit device address, an auto-incrementing 8-bit register
// pointer and a one-clk strobe bridge to a synchronous register file.
module i2c_slave_regs #(
    parameter logic [6:0] DEV_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl,
    inout  wire        sda,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_rd,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_WR_BYTE,
        S_WR_ACK,
        S_RD_BYTE,
        S_RD_MACK,
        S_WAIT
    } state_t;

    // [0],[1] synchronize the pin, [2] is the one-sample history for edge detection
    logic [2:0] scl_q;
    logic [2:0] sda_q;

    state_t     state_q;
    logic [7:0] shift_q;
    logic [2:0] bit_cnt_q;
    logic       rw_q;
    logic       first_byte_q;
    logic       addr_inc_q;
    logic       sda_oe_q;
    logic [7:0] reg_addr_q;
    logic [7:0] reg_wdata_q;
    logic       reg_we_q;
    logic       reg_rd_q;
    logic       busy_q;

    logic       scl_s;
    logic       scl_h;
    logic       sda_s;
    logic       sda_h;
    logic       scl_rise;
    logic       scl_fall;
    logic       start_det;
    logic       stop_det;
    logic [7:0] byte_in;
    logic       addr_match;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: synchronizers reset to the idle-bus level (both lines high) so the
            // release of reset can never be mistaken for a START or STOP.
            scl_q <= 3'b111;
            sda_q <= 3'b111;
        end else begin
            // NOTE: every clocked assignment is non-blocking so each stage shifts by
            // exactly one clk regardless of statement order.
            scl_q <= {scl_q[1:0], scl};
            sda_q <= {sda_q[1:0], sda};
        end
    end

    assign scl_s = scl_q[1];
    assign scl_h = scl_q[2];
    assign sda_s = sda_q[1];
    assign sda_h = sda_q[2];

    assign scl_rise  = scl_s & ~scl_h;
    assign scl_fall  = ~scl_s & scl_h;
    // scl must be high in both samples; a simultaneous scl/sda change is data
    assign start_det = scl_s & scl_h & sda_h & ~sda_s;
    assign stop_det  = scl_s & scl_h & ~sda_h & sda_s;

    assign byte_in    = {shift_q[6:0], sda_s};
    assign addr_match = (byte_in[7:1] == DEV_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            shift_q      <= 8'h00;
            bit_cnt_q    <= 3'd0;
            rw_q         <= 1'b0;
            first_byte_q <= 1'b0;
            addr_inc_q   <= 1'b0;
            sda_oe_q     <= 1'b0;
            reg_addr_q   <= 8'h00;
            reg_wdata_q  <= 8'h00;
            reg_we_q     <= 1'b0;
            reg_rd_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            reg_we_q <= 1'b0;
            reg_rd_q <= 1'b0;

            // pointer advances the clk after a write strobe so the strobe sees the old value
            if (addr_inc_q) begin
                reg_addr_q <= reg_addr_q + 8'd1;
                addr_inc_q <= 1'b0;
            end

            if (start_det) begin
                state_q   <= S_ADDR;
                bit_cnt_q <= 3'd0;
                sda_oe_q  <= 1'b0;
            end else if (stop_det) begin
                state_q  <= S_IDLE;
                sda_oe_q <= 1'b0;
                busy_q   <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: ;

                    S_ADDR: begin
                        if (scl_rise) begin
                            shift_q   <= byte_in;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                if (addr_match) begin
                                    rw_q    <= byte_in[0];
                                    busy_q  <= 1'b1;
                                    state_q <= S_ADDR_ACK;
                                end else begin
                                    busy_q  <= 1'b0;
                                    state_q <= S_WAIT;
                                end
                            end
                        end
                    end

                    // first falling edge starts the ACK, the second one ends the 9th clock
                    S_ADDR_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe_q) begin
                                sda_oe_q <= 1'b1;
                            end else begin
                                bit_cnt_q <= 3'd0;
                                if (rw_q) begin
                                    shift_q  <= reg_rdata;
                                    reg_rd_q <= 1'b1;
                                    sda_oe_q <= ~reg_rdata[7];
                                    state_q  <= S_RD_BYTE;
                                end else begin
                                    sda_oe_q     <= 1'b0;
                                    first_byte_q <= 1'b1;
                                    state_q      <= S_WR_BYTE;
                                end
                            end
                        end
                    end

                    S_WR_BYTE: begin
                        if (scl_rise) begin
                            shift_q   <= byte_in;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                if (first_byte_q) begin
                                    reg_addr_q   <= byte_in;
                                    first_byte_q <= 1'b0;
                                end else begin
                                    reg_wdata_q <= byte_in;
                                    reg_we_q    <= 1'b1;
                                    addr_inc_q  <= 1'b1;
                                end
                                state_q <= S_WR_ACK;
                            end
                        end
                    end

                    S_WR_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe_q) begin
                                sda_oe_q <= 1'b1;
                            end else begin
                                sda_oe_q  <= 1'b0;
                                bit_cnt_q <= 3'd0;
                                state_q   <= S_WR_BYTE;
                            end
                        end
                    end

                    // bit_cnt counts bits already clocked out; wrapping to 0 marks the 8th
                    S_RD_BYTE: begin
                        if (scl_rise) begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt_q == 3'd0) begin
                                sda_oe_q   <= 1'b0;
                                reg_addr_q <= reg_addr_q + 8'd1;
                                state_q    <= S_RD_MACK;
                            end else begin
                                sda_oe_q <= ~shift_q[6];
                                shift_q  <= {shift_q[6:0], 1'b0};
                            end
                        end
                    end

                    // a NACK leaves on the rising edge, so a falling edge here means ACK
                    S_RD_MACK: begin
                        if (scl_rise && sda_s) begin
                            busy_q  <= 1'b0;
                            state_q <= S_WAIT;
                        end else if (scl_fall) begin
                            shift_q   <= reg_rdata;
                            reg_rd_q  <= 1'b1;
                            sda_oe_q  <= ~reg_rdata[7];
                            bit_cnt_q <= 3'd0;
                            state_q   <= S_RD_BYTE;
                        end
                    end

                    S_WAIT: sda_oe_q <= 1'b0;

                    default: begin
                        sda_oe_q <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign sda       = sda_oe_q ? 1'b0 : 1'bz;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_we    = reg_we_q;
    assign reg_rd    = reg_rd_q;
    assign busy      = busy_q;

endmodule
